// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the two-phase clock generator.
package clkgen_pkg;

   typedef enum logic [1:0] {IDLE, ALIGN, RUN, STOP} state_t;

   localparam int CNT_W_DEF = 8;

   // A config is usable when the half period is non-zero and the delay fits inside one full period.
   function automatic logic cfg_ok(input logic [31:0] h, input logic [31:0] p);
      return (h != '0) && (p < {h[30:0], 1'b0});
   endfunction

endpackage

// File: rtl/clkgen_cfg_shadow.sv
// Config shadow: validates loads, holds staged/active half-period and phase, pulses ack/err.
module clkgen_cfg_shadow
   import clkgen_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEF,
   parameter int DEF_HALF  = 5,
   parameter int DEF_PHASE = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_load_i,
   input  logic [CNT_W-1:0] half_i,
   input  logic [CNT_W:0]   phase_i,
   input  logic             boundary_i,
   output logic             apply_o,
   output logic [CNT_W-1:0] half_o,
   output logic [CNT_W:0]   phase_o,
   output logic             ack_o,
   output logic             err_o
);

   logic [CNT_W-1:0] act_half_q, stg_half_q;
   logic [CNT_W:0]   act_phase_q, stg_phase_q;
   logic             pend_q, ack_q, err_q;
   logic             load_ok_d, load_bad_d;

   assign load_ok_d  = cfg_load_i && cfg_ok(32'(half_i), 32'(phase_i));
   assign load_bad_d = cfg_load_i && !load_ok_d;
   assign apply_o    = pend_q && boundary_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_half_q  <= CNT_W'(DEF_HALF);
         act_phase_q <= (CNT_W+1)'(DEF_PHASE);
         stg_half_q  <= '0;
         stg_phase_q <= '0;
         pend_q      <= 1'b0;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         // A load arriving on the apply edge stays pending; the older staged value goes active.
         if (load_ok_d) begin
            stg_half_q  <= half_i;
            stg_phase_q <= phase_i;
            pend_q      <= 1'b1;
         end else if (apply_o) begin
            pend_q      <= 1'b0;
         end
         if (apply_o) begin
            act_half_q  <= stg_half_q;
            act_phase_q <= stg_phase_q;
         end
         ack_q <= apply_o;
         err_q <= load_bad_d;
      end
   end

   assign half_o  = act_half_q;
   assign phase_o = act_phase_q;
   assign ack_o   = ack_q;
   assign err_o   = err_q;

endmodule

// File: rtl/phase_clk_gen.sv
// Two-phase clock generator: divides clk into clk1_o and a phase-delayed clk2_o, 50% duty,
// with glitch-free reconfiguration at period boundaries.
module phase_clk_gen
   import clkgen_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEF,
   parameter int DEF_HALF  = 5,
   parameter int DEF_PHASE = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             cfg_load,
   input  logic [CNT_W-1:0] half_per,
   input  logic [CNT_W:0]   phase,
   output logic             cfg_ack,
   output logic             cfg_err,
   output logic             clk1_o,
   output logic             clk2_o,
   output logic             running
);

   localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);

   state_t           state_q;
   logic [CNT_W:0]   cnt_q, esc_q;
   logic             clk1_q, clk2_q;
   logic [CNT_W-1:0] half;
   logic [CNT_W:0]   ph, two_h, pos2, cnt_d;
   logic             last, boundary, apply, hold2, clk1_d, clk2_d;

   clkgen_cfg_shadow #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF),
      .DEF_PHASE(DEF_PHASE)
   ) u_shadow (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_load_i(cfg_load),
      .half_i    (half_per),
      .phase_i   (phase),
      .boundary_i(boundary),
      .apply_o   (apply),
      .half_o    (half),
      .phase_o   (ph),
      .ack_o     (cfg_ack),
      .err_o     (cfg_err)
   );

   assign two_h    = {half, 1'b0};
   assign last     = (cnt_q == two_h - ONE);
   assign boundary = (state_q == IDLE) || last;
   assign cnt_d    = last ? '0 : cnt_q + ONE;
   // Modular (cnt - P) mod 2H; any intermediate wrap of cnt + 2H cancels in CNT_W+1 bits.
   assign pos2     = cnt_q - ph + ((cnt_q < ph) ? two_h : '0);
   assign hold2    = (esc_q < ph);
   assign clk1_d   = (cnt_q >= {1'b0, half});
   assign clk2_d   = (pos2 >= {1'b0, half}) && !hold2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         esc_q   <= '0;
         clk1_q  <= 1'b0;
         clk2_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               cnt_q  <= '0;
               esc_q  <= '0;
               clk1_q <= 1'b0;
               clk2_q <= 1'b0;
               // Hold off one cycle on a simultaneous load so the run starts on the new config.
               if (en && !cfg_load) state_q <= ALIGN;
            end
            ALIGN: begin
               cnt_q  <= cnt_d;
               clk1_q <= clk1_d;
               clk2_q <= clk2_d;
               if (apply)      esc_q <= '0;
               else if (hold2) esc_q <= esc_q + ONE;
               if (!en)                  state_q <= last ? IDLE : STOP;
               else if (!hold2 && !apply) state_q <= RUN;
            end
            RUN: begin
               cnt_q  <= cnt_d;
               clk1_q <= clk1_d;
               clk2_q <= clk2_d;
               // Saturated so a later, larger phase never re-masks clk2 during STOP.
               esc_q  <= '1;
               if (!en) state_q <= last ? IDLE : STOP;
            end
            STOP: begin
               cnt_q  <= cnt_d;
               clk1_q <= clk1_d;
               clk2_q <= clk2_d;
               if (hold2) esc_q <= esc_q + ONE;
               if (last)  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign clk1_o  = clk1_q;
   assign clk2_o  = clk2_q;
   assign running = (state_q != IDLE);

endmodule

// File: tb/tb_phase_clk_gen.sv
// Self-checking bench for phase_clk_gen: scoreboard of expected {clk1,clk2,ack,err,running} per cycle.
module tb_phase_clk_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       en = 1'b0;
   logic       cfg_load = 1'b0;
   logic [7:0] half_per = '0;
   logic [8:0] phase = '0;
   logic       cfg_ack, cfg_err, clk1_o, clk2_o, running;
   logic [4:0] obs;
   logic [4:0] exp_v;
   logic [4:0] sb[$];
   int         checks = 0;
   int         errors = 0;

   phase_clk_gen #(.CNT_W(8), .DEF_HALF(5), .DEF_PHASE(5)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .cfg_load(cfg_load),
      .half_per(half_per),
      .phase   (phase),
      .cfg_ack (cfg_ack),
      .cfg_err (cfg_err),
      .clk1_o  (clk1_o),
      .clk2_o  (clk2_o),
      .running (running)
   );

   always #5 clk = ~clk;

   assign obs = {clk1_o, clk2_o, cfg_ack, cfg_err, running};

   // k = number of reference cycles counted since the run started (negative: not yet).
   function automatic logic e1(int k, int h);
      return (k >= 0) && ((k % (2 * h)) >= h);
   endfunction

   function automatic logic e2(int k, int h, int p);
      return (k >= p) && (((k - p) % (2 * h)) >= h);
   endfunction

   function automatic logic [4:0] ev(int k, int h, int p, logic ack, logic err, logic run);
      return {e1(k, h), e2(k, h, p), ack, err, run};
   endfunction

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic hard_reset;
      rst_n = 1'b0; en = 1'b0; cfg_load = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset;
      #1 rst_n = 1'b0;
      #2;
      checks++;
      if (obs !== 5'b00000) begin errors++; $display("FAIL reset_async: got %b expected %b", obs, 5'b00000); end
      tick();
      checks++;
      if (obs !== 5'b00000) begin errors++; $display("FAIL reset_held: got %b expected %b", obs, 5'b00000); end
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (obs !== 5'b00000) begin errors++; $display("FAIL reset_idle c%0d: got %b expected %b", i, obs, 5'b00000); end
      end
   endtask

   task automatic test_default_run;
      hard_reset();
      for (int m = 0; m < 30; m++) sb.push_back(ev(m - 1, 5, 5, 1'b0, 1'b0, 1'b1));
      for (int m = 0; m < 30; m++) begin
         en = 1'b1;
         tick();
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL default_run m=%0d: got %b expected %b", m, obs, exp_v); end
      end
   endtask

   task automatic test_reconfig;
      hard_reset();
      for (int m = 0; m < 41; m++) begin
         int  k;
         logic c;
         k = m - 1;
         c = ((k - 20) % 6) >= 3;
         if (k <= 19) sb.push_back(ev(k, 5, 5, m == 20, 1'b0, 1'b1));
         else         sb.push_back({c, c, 1'b0, 1'b0, 1'b1});
      end
      for (int m = 0; m < 41; m++) begin
         en = 1'b1;
         cfg_load = (m == 13);
         half_per = 8'd3;
         phase = 9'd0;
         tick();
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL reconfig m=%0d: got %b expected %b", m, obs, exp_v); end
      end
      cfg_load = 1'b0;
   endtask

   task automatic test_cfg_err;
      hard_reset();
      for (int m = 0; m < 26; m++) sb.push_back(ev(m - 1, 5, 5, 1'b0, (m == 3) || (m == 6), 1'b1));
      for (int m = 0; m < 26; m++) begin
         en = 1'b1;
         cfg_load = (m == 3) || (m == 6);
         half_per = (m == 3) ? 8'd4 : 8'd0;
         phase = (m == 3) ? 9'd8 : 9'd0;
         tick();
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL cfg_err m=%0d: got %b expected %b", m, obs, exp_v); end
      end
      cfg_load = 1'b0;
   endtask

   task automatic test_stop;
      hard_reset();
      cfg_load = 1'b1; half_per = 8'd4; phase = 9'd2;
      tick();
      checks++;
      if (obs !== 5'b00000) begin errors++; $display("FAIL stop_stage: got %b expected %b", obs, 5'b00000); end
      cfg_load = 1'b0;
      tick();
      checks++;
      if (obs !== 5'b00100) begin errors++; $display("FAIL stop_ack: got %b expected %b", obs, 5'b00100); end
      for (int m = 0; m < 13; m++) begin
         if (m <= 8) sb.push_back(ev(m - 1, 4, 2, 1'b0, 1'b0, m <= 7));
         else        sb.push_back(5'b00000);
      end
      for (int m = 0; m < 13; m++) begin
         en = (m < 2);
         tick();
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL stop m=%0d: got %b expected %b", m, obs, exp_v); end
      end
   endtask

   task automatic test_load_with_en;
      hard_reset();
      cfg_load = 1'b1; half_per = 8'd2; phase = 9'd3; en = 1'b1;
      tick();
      checks++;
      if (obs !== 5'b00000) begin errors++; $display("FAIL load_en_idle: got %b expected %b", obs, 5'b00000); end
      cfg_load = 1'b0;
      for (int m = 0; m < 16; m++) sb.push_back(ev(m - 1, 2, 3, m == 0, 1'b0, 1'b1));
      for (int m = 0; m < 16; m++) begin
         tick();
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL load_en m=%0d: got %b expected %b", m, obs, exp_v); end
      end
   endtask

   task automatic test_reset_mid;
      hard_reset();
      for (int m = 0; m < 8; m++) sb.push_back(ev(m - 1, 5, 5, 1'b0, 1'b0, 1'b1));
      for (int m = 0; m < 8; m++) begin
         en = 1'b1;
         cfg_load = (m == 3);
         half_per = 8'd3;
         phase = 9'd1;
         tick();
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL reset_mid_pre m=%0d: got %b expected %b", m, obs, exp_v); end
      end
      cfg_load = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== 5'b00000) begin errors++; $display("FAIL reset_mid_async: got %b expected %b", obs, 5'b00000); end
      en = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (obs !== 5'b00000) begin errors++; $display("FAIL reset_mid_noack c%0d: got %b expected %b", i, obs, 5'b00000); end
      end
      for (int m = 0; m < 21; m++) sb.push_back(ev(m - 1, 5, 5, 1'b0, 1'b0, 1'b1));
      for (int m = 0; m < 21; m++) begin
         en = 1'b1;
         tick();
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL reset_mid_defaults m=%0d: got %b expected %b", m, obs, exp_v); end
      end
   endtask

   initial begin
      test_reset();
      test_default_run();
      test_reconfig();
      test_cfg_err();
      test_stop();
      test_load_with_en();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
